// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared width helper, pointer width and status enum for circular_sync_fifo
package fifo_pkg;

    // Pointer width for a given depth: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_PTR_W = ptr_width(DEFAULT_DEPTH);

    // Coarse occupancy view derived from the full/empty flags.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } status_e;

endpackage

// File: rtl/circular_sync_fifo_if.sv
// rtl/circular_sync_fifo_if.sv - producer/consumer bundle for circular_sync_fifo (SYNC_FIFO_ERR_FLAGS_EN adds overflow/underflow)
interface circular_sync_fifo_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, full, empty, almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, full, empty, almost_full, almost_empty, count,
        output overflow, underflow
    );
`else
    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, full, empty, almost_full, almost_empty, count
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, full, empty, almost_full, almost_empty, count
    );
`endif

endinterface

// File: rtl/fifo_mem_dp.sv
// rtl/fifo_mem_dp.sv - simple dual-port register array with a registered read port
module fifo_mem_dp #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    // Storage: written only on accepted writes, never reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read register: loads on accepted reads, otherwise holds; cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/circular_sync_fifo.sv
// rtl/circular_sync_fifo.sv - parametrised single-clock circular FIFO (SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow)
module circular_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                clk,
    input  logic                reset,
    circular_sync_fifo_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] AF_T = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_T = PTR_W'(AE_THRESH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("circular_sync_fifo: DEPTH must be a power of two >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("circular_sync_fifo: AF_THRESH must be in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
        $error("circular_sync_fifo: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_rd_data;

    // Flags come purely from registered pointers, so they cannot glitch.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                      (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_wr_acc = bus.wr_en && !w_full;
    assign w_rd_acc = bus.rd_en && !w_empty;

    // Pointers advance modulo 2*DEPTH; the extra bit distinguishes full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy tracks accepted operations; a simultaneous accept leaves it unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + PTR_W'(1);
                2'b01:   r_count <= r_count - PTR_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    fifo_mem_dp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (bus.data_in),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

    assign bus.data_out     = w_rd_data;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.count        = r_count;
    assign bus.almost_full  = (r_count >= AF_T);
    assign bus.almost_empty = (r_count <= AE_T);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags: any request against the blocking condition sets them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`endif

endmodule
